// File: rtl/sipo_deserializer_if.sv
// sipo_deserializer_if: serial bit strobe input and parallel word output with valid/ready.
interface sipo_deserializer_if #(parameter int WIDTH = 4);
    logic             din;
    logic             shift;
    logic             flush;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             busy;
    logic             overrun;

    modport master (
        output din, shift, flush, dout_ready,
        input  dout, dout_valid, busy, overrun
    );

    modport slave (
        input  din, shift, flush, dout_ready,
        output dout, dout_valid, busy, overrun
    );
endinterface

// File: rtl/sipo_deserializer.sv
// sipo_deserializer: assembles WIDTH serial bits into a parallel word with a
// single-entry output buffer; a word completing into a full buffer is dropped.
module sipo_deserializer #(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1
) (
    input logic                 clk,
    input logic                 clr,
    sipo_deserializer_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] sr, sr_nxt;
    logic [CW-1:0]    cnt;
    logic             done, stall;

    always_comb begin
        sr_nxt = LSB_FIRST ? {bus.din, sr[WIDTH-1:1]} : {sr[WIDTH-2:0], bus.din};
        done   = bus.shift && !bus.flush && (cnt == CW'(WIDTH - 1));
        stall  = bus.dout_valid && !bus.dout_ready;
    end

    assign bus.busy = (cnt != '0);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sr             <= '0;
            cnt            <= '0;
            bus.dout       <= '0;
            bus.dout_valid <= 1'b0;
            bus.overrun    <= 1'b0;
        end else begin
            if (bus.flush) begin
                sr          <= '0;
                cnt         <= '0;
                bus.overrun <= 1'b0;
            end else if (bus.shift) begin
                sr  <= sr_nxt;
                cnt <= done ? '0 : cnt + 1'b1;
            end
            // a completion into a held word is lost, the old word stays
            if (done && !stall) begin
                bus.dout       <= sr_nxt;
                bus.dout_valid <= 1'b1;
            end else if (bus.dout_valid && bus.dout_ready) begin
                bus.dout_valid <= 1'b0;
            end
            if (done && stall)
                bus.overrun <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sipo_deserializer.sv
// tb_sipo_deserializer: directed vector table driving an LSB-first and an MSB-first
// instance with identical stimulus, plus an asynchronous mid-word reset sequence.
module tb_sipo_deserializer;
    typedef struct {
        logic       din, shift, flush, rdy;
        logic [3:0] da, db;
        logic       v, b, o;
    } vec_t;

    logic clk = 1'b0;
    logic clr = 1'b0;
    int   nchk = 0;
    int   nerr = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    sipo_deserializer_if #(.WIDTH(4)) ia ();
    sipo_deserializer_if #(.WIDTH(4)) ib ();

    sipo_deserializer #(.WIDTH(4), .LSB_FIRST(1)) dut_a (.clk(clk), .clr(clr), .bus(ia.slave));
    sipo_deserializer #(.WIDTH(4), .LSB_FIRST(0)) dut_b (.clk(clk), .clr(clr), .bus(ib.slave));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] da, input logic [3:0] db,
                           input logic v, input logic b, input logic o);
        chk({tag, " dout_a"}, 32'(ia.dout), 32'(da));
        chk({tag, " dout_b"}, 32'(ib.dout), 32'(db));
        chk({tag, " valid"}, 32'({ia.dout_valid, ib.dout_valid}), 32'({v, v}));
        chk({tag, " busy"}, 32'({ia.busy, ib.busy}), 32'({b, b}));
        chk({tag, " overrun"}, 32'({ia.overrun, ib.overrun}), 32'({o, o}));
    endtask

    task automatic add(input logic din, input logic sh, input logic fl, input logic rdy,
                       input logic [3:0] da, input logic [3:0] db,
                       input logic v, input logic b, input logic o);
        vec_t e;
        e = '{din, sh, fl, rdy, da, db, v, b, o};
        tbl.push_back(e);
    endtask

    task automatic gaps(input int n, input logic [3:0] da, input logic [3:0] db, input logic b);
        for (int k = 0; k < n; k++) add(1, 0, 0, 1, da, db, 0, b, 0);
    endtask

    // inputs change on the falling edge, outputs are checked one falling edge later
    task automatic run_vec(input vec_t e, input string tag);
        ia.din = e.din;   ib.din = e.din;
        ia.shift = e.shift; ib.shift = e.shift;
        ia.flush = e.flush; ib.flush = e.flush;
        ia.dout_ready = e.rdy; ib.dout_ready = e.rdy;
        @(negedge clk);
        chk_all(tag, e.da, e.db, e.v, e.b, e.o);
    endtask

    initial begin
        ia.din = 0; ia.shift = 0; ia.flush = 0; ia.dout_ready = 0;
        ib.din = 0; ib.shift = 0; ib.flush = 0; ib.dout_ready = 0;

        // bits 1,0,1,1 back to back: LSB-first D, MSB-first B, valid one cycle
        add(1,1,0,1, 4'h0,4'h0, 0,1,0);
        add(0,1,0,1, 4'h0,4'h0, 0,1,0);
        add(1,1,0,1, 4'h0,4'h0, 0,1,0);
        add(1,1,0,1, 4'hD,4'hB, 1,0,0);
        add(0,0,0,1, 4'hD,4'hB, 0,0,0);
        // same bits separated by 3-cycle gaps with din toggled to 1
        add(1,1,0,1, 4'hD,4'hB, 0,1,0); gaps(3, 4'hD, 4'hB, 1);
        add(0,1,0,1, 4'hD,4'hB, 0,1,0); gaps(3, 4'hD, 4'hB, 1);
        add(1,1,0,1, 4'hD,4'hB, 0,1,0); gaps(3, 4'hD, 4'hB, 1);
        add(1,1,0,1, 4'hD,4'hB, 1,0,0);
        add(0,0,0,1, 4'hD,4'hB, 0,0,0);
        // ready low: word 5/A held, following word (bits 1,1,0,0) dropped -> overrun
        add(1,1,0,0, 4'hD,4'hB, 0,1,0);
        add(0,1,0,0, 4'hD,4'hB, 0,1,0);
        add(1,1,0,0, 4'hD,4'hB, 0,1,0);
        add(0,1,0,0, 4'h5,4'hA, 1,0,0);
        add(1,1,0,0, 4'h5,4'hA, 1,1,0);
        add(1,1,0,0, 4'h5,4'hA, 1,1,0);
        add(0,1,0,0, 4'h5,4'hA, 1,1,0);
        add(0,1,0,0, 4'h5,4'hA, 1,0,1);
        add(0,0,0,0, 4'h5,4'hA, 1,0,1);
        add(0,0,0,1, 4'h5,4'hA, 0,0,1);
        add(0,0,1,0, 4'h5,4'hA, 0,0,0);
        // word 6 held, next word (1,1,1,0) completes on the consuming edge
        add(0,1,0,0, 4'h5,4'hA, 0,1,0);
        add(1,1,0,0, 4'h5,4'hA, 0,1,0);
        add(1,1,0,0, 4'h5,4'hA, 0,1,0);
        add(0,1,0,0, 4'h6,4'h6, 1,0,0);
        add(1,1,0,0, 4'h6,4'h6, 1,1,0);
        add(1,1,0,0, 4'h6,4'h6, 1,1,0);
        add(1,1,0,0, 4'h6,4'h6, 1,1,0);
        add(0,1,0,1, 4'h7,4'hE, 1,0,0);
        add(0,0,0,1, 4'h7,4'hE, 0,0,0);
        // two bits then flush with shift=1; next word 0,1,1,0
        add(1,1,0,1, 4'h7,4'hE, 0,1,0);
        add(1,1,0,1, 4'h7,4'hE, 0,1,0);
        add(1,1,1,1, 4'h7,4'hE, 0,0,0);
        add(0,1,0,1, 4'h7,4'hE, 0,1,0);
        add(1,1,0,1, 4'h7,4'hE, 0,1,0);
        add(1,1,0,1, 4'h7,4'hE, 0,1,0);
        add(0,1,0,1, 4'h6,4'h6, 1,0,0);
        add(0,0,0,1, 4'h6,4'h6, 0,0,0);

        @(negedge clk);
        @(negedge clk);
        chk_all("reset", 4'h0, 4'h0, 0, 0, 0);
        clr = 1'b1;

        foreach (tbl[i]) run_vec(tbl[i], $sformatf("v%0d", i));

        // hold a word, start another, then drop clr between edges
        run_vec('{1,1,0,0, 4'h6,4'h6, 0,1,0}, "r0");
        run_vec('{0,1,0,0, 4'h6,4'h6, 0,1,0}, "r1");
        run_vec('{1,1,0,0, 4'h6,4'h6, 0,1,0}, "r2");
        run_vec('{1,1,0,0, 4'hD,4'hB, 1,0,0}, "r3");
        run_vec('{0,1,0,0, 4'hD,4'hB, 1,1,0}, "r4");
        run_vec('{0,1,0,0, 4'hD,4'hB, 1,1,0}, "r5");
        @(posedge clk);
        #2 clr = 1'b0;
        #1 chk_all("async_clr", 4'h0, 4'h0, 0, 0, 0);
        @(negedge clk);
        chk_all("clr_held", 4'h0, 4'h0, 0, 0, 0);
        clr = 1'b1;
        run_vec('{1,1,0,1, 4'h0,4'h0, 0,1,0}, "p0");
        run_vec('{1,1,0,1, 4'h0,4'h0, 0,1,0}, "p1");
        run_vec('{1,1,0,1, 4'h0,4'h0, 0,1,0}, "p2");
        run_vec('{1,1,0,1, 4'hF,4'hF, 1,0,0}, "p3");
        run_vec('{0,0,0,1, 4'hF,4'hF, 0,0,0}, "p4");

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
